fetch_stage: RTL

Instruction fetch front end feeding decode in the out-of-order core. It owns the architectural fetch PC (`pc_reg`) and issues one request per cycle to a synchronous instruction memory with 1-cycle read latency. Returned instructions are buffered in a 2-entry FIFO and presented to decode over a valid/ready handshake. It redirects the PC on a taken branch or jalr from the branch unit, or on a ROB mispredict, and flushes all fetched-but-unconsumed work when it does.

---
 rtl/fetch_stage.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the fetch PC and drives a 1-cycle-latency imem.
// Responses are buffered in a 2-entry FIFO and handed to decode over valid/ready.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        v_fetch,
    input  logic        r_fetch,
    output logic        fetch_fire,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc_4,
    output logic [31:0] pc_reg
);

    localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

    logic [31:0] r_pc;
    logic [31:0] r_issue_pc;
    logic        r_inflight;
    logic        r_drop;
    logic [31:0] r_q_pc    [2];
    logic [31:0] r_q_instr [2];
    logic [1:0]  r_count;
    logic        r_head;
    logic        r_tail;

    logic        w_rsp;
    logic        w_empty;
    logic        w_byp;
    logic        w_push;
    logic        w_pop;
    logic [2:0]  w_occ;

    assign w_rsp   = r_inflight & ~r_drop;
    assign w_empty = (r_count == 2'd0);
    // An empty FIFO presents the arriving response directly so a request
    // issued in cycle t is visible to decode in t+1.
    assign w_byp   = w_empty & w_rsp;

    assign v_fetch    = ~w_empty | w_rsp;
    assign fetch_fire = v_fetch & r_fetch;

    assign w_occ = {1'b0, r_count} + {2'b00, r_inflight}
                 - {2'b00, fetch_fire};

    assign imem_req  = reset & ~redirect_valid & (w_occ < DEPTH);
    assign imem_addr = r_pc;
    assign pc_reg    = r_pc;

    assign w_push = w_rsp & ~(w_byp & fetch_fire) & ~redirect_valid;
    assign w_pop  = fetch_fire & ~w_empty;

    always_comb begin
        fetch_pc    = r_q_pc[r_head];
        fetch_instr = r_q_instr[r_head];
        if (w_byp) begin
            fetch_pc    = r_issue_pc;
            fetch_instr = imem_rdata;
        end
    end

    assign fetch_pc_4 = fetch_pc + 32'd4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc         <= RESET_PC;
            r_issue_pc   <= '0;
            r_inflight   <= 1'b0;
            r_drop       <= 1'b0;
            r_q_pc[0]    <= '0;
            r_q_pc[1]    <= '0;
            r_q_instr[0] <= '0;
            r_q_instr[1] <= '0;
            r_count      <= '0;
            r_head       <= 1'b0;
            r_tail       <= 1'b0;
        end else if (redirect_valid) begin
            r_pc       <= redirect_pc;
            r_inflight <= imem_req;
            r_drop     <= 1'b1;
            r_count    <= '0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
        end else begin
            r_inflight <= imem_req;
            r_drop     <= 1'b0;
            if (imem_req) begin
                r_pc       <= r_pc + 32'd4;
                r_issue_pc <= r_pc;
            end
            if (w_push) begin
                r_q_pc[r_tail]    <= r_issue_pc;
                r_q_instr[r_tail] <= imem_rdata;
                r_tail            <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
